pll_reconfig_ctrl: RTL

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

---
 rtl/pll_ctrl_pkg.sv | 34 +++
 rtl/pll_reconfig_ctrl_if.sv | 9 +
 rtl/pll_lock_filter.sv | 44 ++++
 rtl/pll_reconfig_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reconfiguration controller.
// Divider selects are encoded as (divide ratio - 1).
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        StRstHold  = 2'd0,
        StWaitLock = 2'd1,
        StLocked   = 2'd2,
        StError    = 2'd3
    } pll_state_e;

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } pll_sel_t;

    localparam int unsigned NumModes   = 4;
    // Lock timeouts retried before giving up (auto-retry build only).
    localparam int unsigned RetryLimit = 3;

    // Mode table; entry 0 is the power-up setting: 27 MHz in, /9, x32, /2 out.
    function automatic pll_sel_t mode_sel(input logic [1:0] mode);
        pll_sel_t sel;
        case (mode)
            2'd0:    sel = '{idsel: 6'd8, fbdsel: 6'd31, odsel: 6'd1};
            2'd1:    sel = '{idsel: 6'd1, fbdsel: 6'd10, odsel: 6'd1};
            2'd2:    sel = '{idsel: 6'd4, fbdsel: 6'd27, odsel: 6'd1};
            default: sel = '{idsel: 6'd2, fbdsel: 6'd39, odsel: 6'd3};
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// Mode-change request handshake between a requester and the PLL controller.
interface pll_reconfig_ctrl_if;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       req_ready;

    modport master (output req_valid, output req_mode, input req_ready);
    modport slave  (input req_valid, input req_mode, output req_ready);
endinterface

// File: rtl/pll_lock_filter.sv
// Lock filter: 2-flop synchronizer on the raw PLL lock plus a saturating
// counter of consecutive synchronized-high cycles while counting is enabled.
module pll_lock_filter #(
    parameter int unsigned LOCK_STABLE_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_async_i,
    input  logic count_en_i,
    output logic lock_sync_o,
    output logic stable_o
);
    localparam int unsigned CntW = $clog2(LOCK_STABLE_CYC + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(LOCK_STABLE_CYC);
    localparam logic [CntW-1:0] CntLast = CntW'(LOCK_STABLE_CYC - 1);

    logic [1:0]      sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Shift the raw lock through the synchronizer; count while high, clear on low.
    always_comb begin
        sync_d = {sync_q[0], lock_async_i};
        cnt_d  = '0;
        if (count_en_i && sync_q[1]) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        end
    end

    // Synchronizer and stability counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lock_sync_o = sync_q[1];
    // Asserted in the cycle that completes the stable run, so the FSM moves on that edge.
    assign stable_o    = count_en_i & sync_q[1] & (cnt_q >= CntLast);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration controller: holds PLL reset, waits for a stable lock,
// releases the pixel-domain reset and services mode-change requests.
// Optional macro PLL_CTRL_AUTO_RETRY_EN: retry lock timeouts before ERROR.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RESET_HOLD_CYC   = 16,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYC = 1048576
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pll_reconfig_ctrl_if.slave        req,
    input  logic                      pll_lock,
    output logic                      pll_reset,
    output logic [5:0]                pll_idsel,
    output logic [5:0]                pll_fbdsel,
    output logic [5:0]                pll_odsel,
    output logic                      pix_rst_n,
    output logic                      busy,
    output logic                      locked,
    output logic                      err_timeout,
    output logic [1:0]                cur_mode
);
    localparam int unsigned HoldW = $clog2(RESET_HOLD_CYC + 1);
    localparam int unsigned TmoW  = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(RESET_HOLD_CYC);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD_CYC - 1);
    localparam logic [TmoW-1:0]  TmoMax   = TmoW'(LOCK_TIMEOUT_CYC);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(LOCK_TIMEOUT_CYC - 1);

    pll_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [1:0]       mode_q, mode_d;
    pll_sel_t         sel_q, sel_d;
`ifdef PLL_CTRL_AUTO_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif
    logic pll_reset_q, pll_reset_d;
    logic pix_rst_n_q, pix_rst_n_d;
    logic locked_q, locked_d;
    logic busy_q, busy_d;
    logic err_q, err_d;
    logic ready_q, ready_d;

    logic accept;
    logic lock_sync;
    logic lock_stable;

    assign accept = req.req_valid & ready_q;

    pll_lock_filter #(
        .LOCK_STABLE_CYC (LOCK_STABLE_CYC)
    ) u_lock_filter (
        .clk          (clk),
        .rst_n        (rst_n),
        .lock_async_i (pll_lock),
        .count_en_i   (state_q == StWaitLock),
        .lock_sync_o  (lock_sync),
        .stable_o     (lock_stable)
    );

    // Next-state, counters and mode latch; an accepted request overrides everything.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        tmo_cnt_d  = '0;
        mode_d     = mode_q;
        sel_d      = sel_q;
`ifdef PLL_CTRL_AUTO_RETRY_EN
        retry_d    = retry_q;
`endif
        unique case (state_q)
            StRstHold: begin
                if (hold_cnt_q == HoldLast) begin
                    state_d = StWaitLock;
                end else begin
                    hold_cnt_d = (hold_cnt_q == HoldMax) ? hold_cnt_q
                                                         : hold_cnt_q + HoldW'(1);
                end
            end
            StWaitLock: begin
                if (lock_stable) begin
                    state_d = StLocked;
`ifdef PLL_CTRL_AUTO_RETRY_EN
                    retry_d = 2'd0;
`endif
                end else if (tmo_cnt_q == TmoLast) begin
`ifdef PLL_CTRL_AUTO_RETRY_EN
                    if (retry_q != 2'(RetryLimit)) begin
                        state_d = StRstHold;
                        retry_d = retry_q + 2'd1;
                    end else begin
                        state_d = StError;
                    end
`else
                    state_d = StError;
`endif
                end else begin
                    tmo_cnt_d = (tmo_cnt_q == TmoMax) ? tmo_cnt_q : tmo_cnt_q + TmoW'(1);
                end
            end
            StLocked: begin
                if (!lock_sync) begin
                    state_d = StRstHold;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StRstHold;
            end
        endcase

        if (accept) begin
            state_d = StRstHold;
            mode_d  = req.req_mode;
            sel_d   = mode_sel(req.req_mode);
`ifdef PLL_CTRL_AUTO_RETRY_EN
            retry_d = 2'd0;
`endif
        end
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_comb begin
        pll_reset_d = (state_d == StRstHold) || (state_d == StError);
        pix_rst_n_d = (state_d == StLocked);
        locked_d    = (state_d == StLocked);
        busy_d      = (state_d == StRstHold) || (state_d == StWaitLock);
        err_d       = (state_d == StError);
        ready_d     = (state_d == StLocked) || (state_d == StError);
    end

    // State, counters, mode/select and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRstHold;
            hold_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            mode_q      <= 2'd0;
            sel_q       <= mode_sel(2'd0);
`ifdef PLL_CTRL_AUTO_RETRY_EN
            retry_q     <= 2'd0;
`endif
            pll_reset_q <= 1'b1;
            pix_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mode_q      <= mode_d;
            sel_q       <= sel_d;
`ifdef PLL_CTRL_AUTO_RETRY_EN
            retry_q     <= retry_d;
`endif
            pll_reset_q <= pll_reset_d;
            pix_rst_n_q <= pix_rst_n_d;
            locked_q    <= locked_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    assign req.req_ready = ready_q;
    assign pll_reset     = pll_reset_q;
    assign pll_idsel     = sel_q.idsel;
    assign pll_fbdsel    = sel_q.fbdsel;
    assign pll_odsel     = sel_q.odsel;
    assign pix_rst_n     = pix_rst_n_q;
    assign busy          = busy_q;
    assign locked        = locked_q;
    assign err_timeout   = err_q;
    assign cur_mode      = mode_q;

endmodule
